// File: rtl/mos6502_pkg.sv
// Shared types and constants for the 6502 instruction sequencer.
package mos6502_pkg;

    // Sequencer state codes; code 7 is unused and recovers to fetch.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_T1     = 3'd1,
        ST_OP2    = 3'd2,
        ST_IDX    = 3'd3,
        ST_PTR_LO = 3'd4,
        ST_PTR_HI = 3'd5,
        ST_EXEC   = 3'd6
    } state_e;

    // Resolved addressing mode after priority encoding.
    typedef enum logic [3:0] {
        MODE_IMP  = 4'd0,
        MODE_A    = 4'd1,
        MODE_REL  = 4'd2,
        MODE_HASH = 4'd3,
        MODE_ZPG  = 4'd4,
        MODE_ZPGX = 4'd5,
        MODE_ABS  = 4'd6,
        MODE_ABSY = 4'd7,
        MODE_ABSX = 4'd8,
        MODE_IND  = 4'd9,
        MODE_INDY = 4'd10,
        MODE_XIND = 4'd11
    } mode_e;

    // Bit positions in the decoder flag bus {Xind,indY,ind,absX,absY,abs,zpgX,zpg,hash,rel,A}.
    localparam int MB_A    = 0;
    localparam int MB_REL  = 1;
    localparam int MB_HASH = 2;
    localparam int MB_ZPG  = 3;
    localparam int MB_ZPGX = 4;
    localparam int MB_ABS  = 5;
    localparam int MB_ABSY = 6;
    localparam int MB_ABSX = 7;
    localparam int MB_IND  = 8;
    localparam int MB_INDY = 9;
    localparam int MB_XIND = 10;

    localparam logic [7:0] OPC_NOP = 8'hEA;

endpackage

// File: rtl/mos6502_mode_enc.sv
// Priority encoder: decoder mode flags to a single mode code, Xind highest.
module mos6502_mode_enc
    import mos6502_pkg::*;
(
    input  logic [10:0] flags,
    output mode_e       mode
);

    // Highest-priority set flag wins; no flag set means implied.
    always_comb begin
        mode = MODE_IMP;
        if      (flags[MB_XIND]) mode = MODE_XIND;
        else if (flags[MB_INDY]) mode = MODE_INDY;
        else if (flags[MB_IND])  mode = MODE_IND;
        else if (flags[MB_ABSX]) mode = MODE_ABSX;
        else if (flags[MB_ABSY]) mode = MODE_ABSY;
        else if (flags[MB_ABS])  mode = MODE_ABS;
        else if (flags[MB_ZPGX]) mode = MODE_ZPGX;
        else if (flags[MB_ZPG])  mode = MODE_ZPG;
        else if (flags[MB_HASH]) mode = MODE_HASH;
        else if (flags[MB_REL])  mode = MODE_REL;
        else if (flags[MB_A])    mode = MODE_A;
    end

endmodule

// File: rtl/mos6502_sequencer.sv
// 6502 cycle sequencer: opcode latch, addressing-mode register and
// per-cycle strobes for operand, pointer and index handling.
module mos6502_sequencer
    import mos6502_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        rdy,
    input  logic [10:0] mode_in,
    input  logic        ldx_y,
    output logic [7:0]  ir,
    output logic        sync,
    output logic [2:0]  tstate,
    output logic        pc_inc,
    output logic        op_lo_we,
    output logic        op_hi_we,
    output logic        ptr_lo_we,
    output logic        ptr_hi_we,
    output logic        idx_en,
    output logic        exec,
    output logic        idx_y
);

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    mode_e      mode_q, mode_d;
    logic       idx_y_q, idx_y_d;
    mode_e      enc_mode;
    logic       enc_idx_y;
    // Raw strobes {pc_inc,op_lo,op_hi,ptr_lo,ptr_hi,idx_en,exec} before rdy/reset gating.
    logic [6:0] sb_raw;
    logic       sb_en;

    mos6502_mode_enc u_mode_enc (
        .flags (mode_in),
        .mode  (enc_mode)
    );

    // Index register choice for the instruction being decoded in T1.
    assign enc_idx_y = (enc_mode == MODE_ABSY) || (enc_mode == MODE_INDY) ||
                       (((enc_mode == MODE_ZPGX) || (enc_mode == MODE_ABSX)) && ldx_y);

    // Next-state, register updates and raw strobe decode.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        mode_d  = mode_q;
        idx_y_d = idx_y_q;
        sb_raw  = 7'b0;
        case (state_q)
            ST_FETCH: begin
                sb_raw[6] = 1'b1;
                if (rdy) begin
                    ir_d    = data_in;
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                if (enc_mode == MODE_IMP || enc_mode == MODE_A) sb_raw[0] = 1'b1;
                else                                            sb_raw[6:5] = 2'b11;
                if (rdy) begin
                    mode_d  = enc_mode;
                    idx_y_d = enc_idx_y;
                    case (enc_mode)
                        MODE_HASH, MODE_ZPG, MODE_REL:            state_d = ST_EXEC;
                        MODE_ZPGX, MODE_XIND:                     state_d = ST_IDX;
                        MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND: state_d = ST_OP2;
                        MODE_INDY:                                state_d = ST_PTR_LO;
                        default:                                  state_d = ST_FETCH;
                    endcase
                end
            end
            ST_OP2: begin
                sb_raw[6] = 1'b1;
                sb_raw[4] = 1'b1;
                if (rdy) begin
                    if (mode_q == MODE_IND)      state_d = ST_PTR_LO;
                    else if (mode_q == MODE_ABS) state_d = ST_EXEC;
                    else                         state_d = ST_IDX;
                end
            end
            ST_IDX: begin
                sb_raw[1] = 1'b1;
                if (rdy) state_d = (mode_q == MODE_XIND) ? ST_PTR_LO : ST_EXEC;
            end
            ST_PTR_LO: begin
                sb_raw[3] = 1'b1;
                if (rdy) state_d = ST_PTR_HI;
            end
            ST_PTR_HI: begin
                sb_raw[2] = 1'b1;
                if (rdy) state_d = (mode_q == MODE_INDY) ? ST_IDX : ST_EXEC;
            end
            ST_EXEC: begin
                sb_raw[0] = 1'b1;
                if (rdy) begin
                    idx_y_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Single state/opcode/mode register bank; reset parks on a NOP fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= OPC_NOP;
            mode_q  <= MODE_IMP;
            idx_y_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            mode_q  <= mode_d;
            idx_y_q <= idx_y_d;
        end
    end

    // Strobes are suppressed while stalled and while reset is held.
    assign sb_en = rdy & rst_n;
    assign {pc_inc, op_lo_we, op_hi_we, ptr_lo_we, ptr_hi_we, idx_en, exec} =
        sb_raw & {7{sb_en}};

    assign ir     = ir_q;
    assign sync   = (state_q == ST_FETCH);
    assign tstate = state_q;
    // During T1 the index select follows the live decode so it is valid from T1 on.
    assign idx_y  = (state_q == ST_T1) ? enc_idx_y : idx_y_q;

endmodule

// File: tb/tb_mos6502_sequencer.sv
// Directed bench for the 6502 sequencer: per-cycle state/strobe checks.
module tb_mos6502_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        rdy;
    logic [10:0] mode_in;
    logic        ldx_y;
    logic [7:0]  ir;
    logic        sync;
    logic [2:0]  tstate;
    logic        pc_inc, op_lo_we, op_hi_we, ptr_lo_we, ptr_hi_we, idx_en, exec;
    logic        idx_y;

    int n_chk = 0;
    int n_err = 0;
    int seq[$];

    mos6502_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .rdy       (rdy),
        .mode_in   (mode_in),
        .ldx_y     (ldx_y),
        .ir        (ir),
        .sync      (sync),
        .tstate    (tstate),
        .pc_inc    (pc_inc),
        .op_lo_we  (op_lo_we),
        .op_hi_we  (op_hi_we),
        .ptr_lo_we (ptr_lo_we),
        .ptr_hi_we (ptr_hi_we),
        .idx_en    (idx_en),
        .exec      (exec),
        .idx_y     (idx_y)
    );

    always #5 clk = ~clk;

    // Observed strobes {pc_inc,op_lo,op_hi,ptr_lo,ptr_hi,idx_en,exec}.
    wire [6:0] sb = {pc_inc, op_lo_we, op_hi_we, ptr_lo_we, ptr_hi_we, idx_en, exec};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected strobe pattern for a state, from the per-state strobe table.
    function automatic logic [6:0] exp_sb(input int st, input logic impl);
        case (st)
            0:       return 7'b1000000;
            1:       return impl ? 7'b0000001 : 7'b1100000;
            2:       return 7'b1010000;
            3:       return 7'b0000010;
            4:       return 7'b0001000;
            5:       return 7'b0000100;
            6:       return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Runs one instruction from FETCH with rdy=1 against the state list in seq.
    task automatic run(input string nm, input logic [7:0] op, input logic [10:0] md,
                       input logic ly, input logic impl, input logic exp_iy);
        data_in = op;
        mode_in = md;
        ldx_y   = ly;
        rdy     = 1'b1;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            chk({nm, "_st"}, 32'(tstate), 32'(seq[i]));
            chk({nm, "_sb"}, 32'(sb), 32'(exp_sb(seq[i], impl)));
            chk({nm, "_sync"}, 32'(sync), 32'(seq[i] == 0));
            if (i == seq.size() - 1) begin
                chk({nm, "_idxy"}, 32'(idx_y), 32'(exp_iy));
                chk({nm, "_ir"}, 32'(ir), 32'(op));
            end
            @(posedge clk);
            #1;
            data_in = 8'h10 + 8'(i);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rdy     = 1'b1;
        data_in = 8'hE8;
        mode_in = 11'd0;
        ldx_y   = 1'b0;
        #12;
        chk("rst_st", 32'(tstate), 32'd0);
        chk("rst_ir", 32'(ir), 32'hEA);
        chk("rst_sync", 32'(sync), 32'd1);
        chk("rst_sb", 32'(sb), 32'd0);
        chk("rst_idxy", 32'(idx_y), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Implied INX: two cycles, exec in T1.
        seq = '{0, 1};
        run("inx", 8'hE8, 11'd0, 1'b0, 1'b1, 1'b0);
        // Accumulator ASL A.
        seq = '{0, 1};
        run("asla", 8'h0A, 11'h001, 1'b0, 1'b1, 1'b0);
        // Immediate LDA #.
        seq = '{0, 1, 6};
        run("imm", 8'hA9, 11'h004, 1'b0, 1'b0, 1'b0);
        // LDA abs,X.
        seq = '{0, 1, 2, 3, 6};
        run("absx", 8'hBD, 11'h080, 1'b0, 1'b0, 1'b0);
        // LDA (zp),Y.
        seq = '{0, 1, 4, 5, 3, 6};
        run("indy", 8'hB1, 11'h200, 1'b0, 1'b0, 1'b1);
        // LDX zp,Y: zpgX flag with LDX_Y selects Y.
        seq = '{0, 1, 3, 6};
        run("ldxzy", 8'hB6, 11'h010, 1'b1, 1'b0, 1'b1);
        // JMP (ind).
        seq = '{0, 1, 2, 4, 5, 6};
        run("jmpi", 8'h6C, 11'h100, 1'b0, 1'b0, 1'b0);

        // Stall in FETCH: state held, sync still high, strobes off.
        rdy = 1'b0;
        data_in = 8'h55;
        @(negedge clk);
        chk("stf_st", 32'(tstate), 32'd0);
        chk("stf_sync", 32'(sync), 32'd1);
        chk("stf_sb", 32'(sb), 32'd0);
        @(negedge clk);
        chk("stf_ir", 32'(ir), 32'h6C);
        chk("stf_st2", 32'(tstate), 32'd0);
        @(posedge clk);
        #1;

        // LDA abs with a 3-cycle stall in OP2.
        rdy = 1'b1;
        data_in = 8'hAD;
        mode_in = 11'h020;
        @(negedge clk);
        chk("abs_f", 32'(tstate), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abs_t1", 32'(tstate), 32'd1);
        chk("abs_t1sb", 32'(sb), 32'b1100000);
        @(posedge clk);
        #1;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abs_hold_st", 32'(tstate), 32'd2);
            chk("abs_hold_sb", 32'(sb), 32'd0);
            chk("abs_hold_ir", 32'(ir), 32'hAD);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("abs_op2_st", 32'(tstate), 32'd2);
        chk("abs_op2_sb", 32'(sb), 32'b1010000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abs_ex_st", 32'(tstate), 32'd6);
        chk("abs_ex_sb", 32'(sb), 32'b0000001);
        @(posedge clk);
        #1;

        // Xind interrupted by reset in PTR_HI.
        data_in = 8'hA1;
        mode_in = 11'h408;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("xr_phi_st", 32'(tstate), 32'd5);
        chk("xr_phi_sb", 32'(sb), 32'b0000100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("xr_rst_st", 32'(tstate), 32'd0);
        chk("xr_rst_ir", 32'(ir), 32'hEA);
        chk("xr_rst_sb", 32'(sb), 32'd0);
        chk("xr_rst_sync", 32'(sync), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Xind and zpg both set: Xind wins, six cycles.
        seq = '{0, 1, 3, 4, 5, 6};
        run("xind", 8'hA1, 11'h408, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
